tf_addr_gen: RTL and testbench
==============================

# tf_addr_gen

Twiddle-factor sequencer feeding the twiddle ROM and `tf_proc`. For one NTT or INTT pass it generates the ROM read address for every butterfly cycle, in stage order. It also raises `proc_flag` during the INTT scaling phase. `proc_flag` is issued aligned with the address; the consumer delays it by the 2-cycle ROM latency. The block sits between the polynomial-multiplier control FSM (`start`/`done`) and the twiddle ROM.

## Interface
- `LOG_N`, 8: log2 of polynomial length N; N/2 butterflies per stage.
- `clk` input 1: clock.
- `rst_n` input 1: reset, asynchronous, active-low.
- `conf` input 3: mode. 3'b001 selects NTT; 3'b011 selects INTT. Sampled only with an accepted `start`.
- `start` input 1: one-cycle request to begin a pass.
- `stall` input 1: downstream back-pressure; freezes issue while high.
- `busy` output 1: high from the cycle after an accepted `start` until `done`.
- `done` output 1: one-cycle pulse at the end of a pass.
- `tf_rd_en` output 1: twiddle ROM read strobe; `tf_addr` is valid whenever this is high.
- `tf_addr` output LOG_N: twiddle ROM address.
- `proc_flag` output 1: high with `tf_rd_en` during the INTT scaling phase.
- `stage` output $clog2(LOG_N)+1: current stage index, for debug and control.

## Operation
- States: IDLE, RUN, SCALE, DONE.
- **IDLE**
  - `start`=1 with a legal `conf` latches `conf_q`, clears `s` and `j`, and moves to RUN.
  - `start` with an illegal `conf` is ignored; the block stays in IDLE.
- **RUN**
  - Each non-stalled cycle issues one address.
  - Counter `j` runs 0..N/2-1 and wraps; on wrap, `s` increments.
  - NTT address: 2^s + (j >> (LOG_N-1-s)).
  - INTT address: 2^(LOG_N-1-s) + (j >> s).
  - After the last issue (s=LOG_N-1, j=N/2-1): NTT goes to DONE; INTT goes to SCALE.
- **SCALE** (INTT only)
  - Issues address 0 (the table holds N⁻¹) for N/2 non-stalled cycles, with `proc_flag`=1.
  - Then goes to DONE.
- **DONE**: asserts `done` for one cycle, then returns to IDLE.
- **Stall**
  - `stall`=1 in RUN or SCALE forces `tf_rd_en`=0 and `proc_flag`=0, and holds `j`, `s` and the state.
  - `tf_addr` holds its last value.
  - Stall in IDLE or DONE has no effect.
- `start` while busy is ignored.
- `stage` tracks `s`; it is 0 in IDLE and in SCALE.
- All address arithmetic is unsigned, LOG_N bits, with no overflow: the maximum address is N-1.

## Timing
- Reset values: `busy`=0, `done`=0, `tf_rd_en`=0, `tf_addr`=0, `proc_flag`=0, `stage`=0, state IDLE.
- All outputs are registered.
- An accepted `start` at edge t gives the first `tf_rd_en` in cycle t+1.
- Length with no stalls:
  - NTT: LOG_N·N/2 issue cycles, then 1 `done` cycle.
  - INTT: (LOG_N+1)·N/2 issue cycles, then 1 `done` cycle.
- Each stall cycle extends the pass by exactly one cycle.
- `done` rises the cycle after the last issue; `busy` falls in the same cycle `done` rises.
- A new `start` is accepted in the cycle after `done`.
- Asserting `rst_n`=0 mid-pass drives all outputs to reset values immediately (asynchronous). No `done` is produced.

## Configuration
- `TF_SCALE_EN` defined:
  - The SCALE phase is compiled in, as described above.
- `TF_SCALE_EN` undefined:
  - The SCALE state is removed; INTT goes from the last RUN issue straight to DONE.
  - `proc_flag` is tied to 0.
  - INTT length becomes LOG_N·N/2.

## Test plan
- LOG_N=3, NTT start with no stall -> `tf_addr` sequence 1,1,1,1,2,2,3,3,4,5,6,7 (12 cycles); `done` on cycle 13; `proc_flag` 0 throughout.
- LOG_N=3, INTT with `TF_SCALE_EN` -> 4,5,6,7,2,2,3,3,1,1,1,1, then 0,0,0,0 with `proc_flag`=1; `done` on cycle 17.
- LOG_N=3, INTT without `TF_SCALE_EN` -> the 12 RUN addresses only; `done` on cycle 13; `proc_flag` never 1.
- NTT with `stall`=1 for 3 cycles after the 5th issue -> `tf_rd_en` low for those 3 cycles, address held at 2, sequence unchanged, `done` on cycle 16.
- `conf`=3'b010 with `start` -> remains IDLE, `busy`=0; a second `start` during a pass -> ignored, pass unaffected.
- `rst_n` pulsed low at the 7th issue -> all outputs 0 in the same cycle; no `done`; a new `start` then runs a full pass correctly.

Source files
------------

// File: rtl/tf_addr_gen.sv
// Twiddle-factor ROM address sequencer for one NTT/INTT pass.
// Define TF_SCALE_EN to compile in the INTT N^-1 scaling phase.
module tf_addr_gen #(
    parameter int LOG_N = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [2:0]             conf,
    input  logic                   start,
    input  logic                   stall,
    output logic                   busy,
    output logic                   done,
    output logic                   tf_rd_en,
    output logic [LOG_N-1:0]       tf_addr,
    output logic                   proc_flag,
    output logic [$clog2(LOG_N):0] stage
);
    localparam int SW = $clog2(LOG_N) + 1;
    localparam int JW = LOG_N - 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] SCALE = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [JW-1:0]    J_LAST = '1;
    localparam logic [SW-1:0]    S_LAST = SW'(LOG_N - 1);
    localparam logic [LOG_N-1:0] ONE    = LOG_N'(1);
    localparam logic [LOG_N-1:0] HALF   = ONE << (LOG_N - 1);

    logic [1:0]       state;
    logic [SW-1:0]    s;
    logic [JW-1:0]    j;
    logic             intt;
    logic             legal;
    logic             j_wrap;
    logic             last;
    logic [SW-1:0]    sh;
    logic [LOG_N-1:0] jx;
    logic [LOG_N-1:0] run_addr;

    assign legal  = (conf == 3'b001) || (conf == 3'b011);
    assign j_wrap = (j == J_LAST);
    assign last   = j_wrap && (s == S_LAST);
    assign jx     = LOG_N'(j);

    // s and j point at the next issue; the start edge emits (0,0) itself
    always_comb begin
        sh       = intt ? s : (S_LAST - s);
        run_addr = (intt ? (HALF >> s) : (ONE << s)) + (jx >> sh);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s        <= '0;
            j        <= '0;
            intt     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            tf_rd_en <= 1'b0;
            tf_addr  <= '0;
            stage    <= '0;
        end else begin
            done     <= 1'b0;
            tf_rd_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start && legal) begin
                        state    <= RUN;
                        intt     <= conf[1];
                        s        <= '0;
                        j        <= JW'(1);
                        busy     <= 1'b1;
                        tf_rd_en <= 1'b1;
                        tf_addr  <= conf[1] ? HALF : ONE;
                        stage    <= '0;
                    end
                end
                RUN: begin
                    if (!stall) begin
                        tf_rd_en <= 1'b1;
                        tf_addr  <= run_addr;
                        stage    <= s;
                        j        <= j + JW'(1);
                        if (j_wrap)
                            s <= s + SW'(1);
                        if (last) begin
                            s <= '0;
                            j <= '0;
`ifdef TF_SCALE_EN
                            state <= intt ? SCALE : DONE;
`else
                            state <= DONE;
`endif
                        end
                    end
                end
                SCALE: begin
`ifdef TF_SCALE_EN
                    if (!stall) begin
                        tf_rd_en <= 1'b1;
                        tf_addr  <= '0;
                        stage    <= '0;
                        j        <= j + JW'(1);
                        if (j_wrap)
                            state <= DONE;
                    end
`else
                    state <= IDLE;
`endif
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    stage <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef TF_SCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            proc_flag <= 1'b0;
        else
            proc_flag <= (state == SCALE) && !stall;
    end
`else
    assign proc_flag = 1'b0;
`endif

endmodule

// File: tb/tb_tf_addr_gen.sv
// Randomized bench for tf_addr_gen against a queue-based pass model.
// Honors TF_SCALE_EN the same way the design does.
module tb_tf_addr_gen;
    localparam int LN = 3;
    localparam int HN = 1 << (LN - 1);
`ifdef TF_SCALE_EN
    localparam bit SCALE_ON = 1'b1;
`else
    localparam bit SCALE_ON = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       conf;
    logic             start;
    logic             stall;
    logic             busy;
    logic             done;
    logic             tf_rd_en;
    logic [LN-1:0]    tf_addr;
    logic             proc_flag;
    logic [$clog2(LN):0] stage;

    int checks = 0;
    int errors = 0;
    int ea[$];
    int ef[$];
    int es[$];
    int got_q[$];
    int done_cyc;
    int ntt_ref[12]  = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7};
    int intt_ref[12] = '{4, 5, 6, 7, 2, 2, 3, 3, 1, 1, 1, 1};

    always #5 clk = ~clk;

    tf_addr_gen #(.LOG_N(LN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .conf      (conf),
        .start     (start),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .tf_rd_en  (tf_rd_en),
        .tf_addr   (tf_addr),
        .proc_flag (proc_flag),
        .stage     (stage)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected issue list for one pass, straight from the address rules
    task automatic build(input bit intt);
        ea = {};
        ef = {};
        es = {};
        for (int s = 0; s < LN; s++)
            for (int j = 0; j < HN; j++) begin
                if (intt)
                    ea.push_back((1 << (LN - 1 - s)) + (j >> s));
                else
                    ea.push_back((1 << s) + (j >> (LN - 1 - s)));
                ef.push_back(0);
                es.push_back(s);
            end
        if (intt && SCALE_ON)
            for (int j = 0; j < HN; j++) begin
                ea.push_back(0);
                ef.push_back(1);
                es.push_back(0);
            end
    endtask

    task automatic run_pass(input bit intt, input int pct, input int st_from,
                            input int st_len, input bit noise);
        int issued;
        int cyc;
        int total;
        int e0;
        bit prev_stall;
        bit exp_en;
        int last_addr;
        build(intt);
        total    = ea.size();
        got_q    = {};
        done_cyc = -1;
        e0       = errors;
        issued   = 0;
        cyc      = 0;
        last_addr = 0;
        conf  = intt ? 3'b011 : 3'b001;
        start = 1'b1;
        stall = ($urandom_range(99) < pct);
        prev_stall = stall;
        while (done_cyc < 0) begin
            @(posedge clk);
            #1;
            cyc++;
            if (issued < total) begin
                exp_en = (cyc == 1) || !prev_stall;
                check("rd_en", tf_rd_en, exp_en);
                check("busy", busy, 1);
                check("done_early", done, 0);
                if (exp_en) begin
                    check("addr", tf_addr, ea[issued]);
                    check("flag", proc_flag, ef[issued]);
                    check("stage", stage, es[issued]);
                    got_q.push_back(int'(tf_addr));
                    last_addr = ea[issued];
                    issued++;
                end else begin
                    check("hold_addr", tf_addr, last_addr);
                    check("flag_stall", proc_flag, 0);
                end
            end else begin
                check("done", done, 1);
                check("busy_end", busy, 0);
                check("rd_en_end", tf_rd_en, 0);
                check("flag_end", proc_flag, 0);
                check("stage_end", stage, 0);
                done_cyc = cyc;
            end
            if (cyc > 20 * total + 50)
                check("timeout", cyc, 0);
            if (errors != e0)
                break;
            start = noise && ($urandom_range(3) == 0);
            if (noise)
                conf = 3'($urandom_range(7));
            stall = ((cyc >= st_from) && (cyc < st_from + st_len)) ||
                    ($urandom_range(99) < pct);
            prev_stall = stall;
        end
        start = 1'b0;
        stall = 1'b0;
        if (errors != e0) begin
            rst_n = 1'b0;
            @(posedge clk);
            #1;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        conf  = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", tf_rd_en, 0);
        check("rst_addr", tf_addr, 0);
        check("rst_flag", proc_flag, 0);
        check("rst_stage", stage, 0);
        rst_n = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #1;
        stall = 1'b0;
        check("idle_stall_busy", busy, 0);

        run_pass(1'b0, 0, 0, 0, 1'b0);
        check("ntt_done_cyc", done_cyc, 13);
        check("ntt_len", got_q.size(), 12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check("ntt_seq", got_q[i], ntt_ref[i]);

        run_pass(1'b1, 0, 0, 0, 1'b0);
        check("intt_done_cyc", done_cyc, SCALE_ON ? 17 : 13);
        check("intt_len", got_q.size(), SCALE_ON ? 16 : 12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check("intt_seq", got_q[i], intt_ref[i]);
        for (int i = 12; i < got_q.size(); i++)
            check("intt_scale_addr", got_q[i], 0);

        conf  = 3'b010;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            check("illegal_busy", busy, 0);
            check("illegal_rd_en", tf_rd_en, 0);
            @(posedge clk);
            #1;
        end

        run_pass(1'b0, 0, 5, 3, 1'b0);
        check("stall_done_cyc", done_cyc, 16);
        check("stall_len", got_q.size(), 12);
        for (int i = 0; i < 12 && i < got_q.size(); i++)
            check("stall_seq", got_q[i], ntt_ref[i]);

        run_pass(1'b0, 0, 0, 0, 1'b1);
        check("noise_done_cyc", done_cyc, 13);

        conf  = 3'b001;
        start = 1'b1;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check("pre_rst_rd_en", tf_rd_en, 1);
        check("pre_rst_addr", tf_addr, 3);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", tf_rd_en, 0);
        check("mid_rst_addr", tf_addr, 0);
        check("mid_rst_flag", proc_flag, 0);
        check("mid_rst_stage", stage, 0);
        check("mid_rst_done", done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk);
            #1;
            check("post_rst_no_done", done, 0);
        end
        run_pass(1'b0, 0, 0, 0, 1'b0);
        check("post_rst_done_cyc", done_cyc, 13);

        for (int p = 0; p < 30; p++)
            run_pass(1'($urandom_range(1)), $urandom_range(40), 0, 0,
                     1'($urandom_range(1)));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
